// File: rtl/dfmul_seq_if.sv
// Bus bundle for the sequential BCD significand multiplier.
//
// Handshake: the master pulses ld (with ce high) while a and b carry the
// operands; the slave drops done after that edge and raises it again when
// p and lzcnt hold the finished product. A new ld is accepted at any time,
// including while a product is in flight (the old one is discarded).
interface dfmul_seq_if #(
  parameter int N = 34
);
  logic           ce;
  logic           ld;
  logic [4*N-1:0] a;
  logic [4*N-1:0] b;
  logic [8*N-1:0] p;
  logic [7:0]     lzcnt;
  logic           done;

  modport master (
    output ce, ld, a, b,
    input  p, lzcnt, done
  );

  modport slave (
    input  ce, ld, a, b,
    output p, lzcnt, done
  );
endinterface

// File: rtl/dfmul_seq.sv
// Sequential packed-BCD significand multiplier: builds multiples 1..9 of a,
// then consumes one multiplier digit per cycle with shift-and-add, and
// finishes with a leading-zero-digit count of the 2N-digit product.
module dfmul_seq #(
  parameter int N = 34
) (
  input  logic        clk,
  input  logic        rst,
  dfmul_seq_if.slave  bus,
  output logic [1:0]  fsm_state
);

  localparam int DW = 4 * (N + 1);

  typedef enum logic [1:0] {IDLE, PRE, MUL, LZC} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [5:0]        cnt;
  logic [DW-1:0]     m [1:9];
  logic [DW-1:0]     acc;
  logic [4*N-1:0]    br;
  logic [8*N-1:0]    p_q;
  logic [7:0]        lzcnt_q;
  logic              done_q;

  logic [DW-1:0]     add_x;
  logic [DW-1:0]     add_y;
  logic [DW-1:0]     sum;
  logic [8*N-1:0]    full;
  logic [6:0]        lz_bin;
  logic [7:0]        lz_bcd;
  logic              seen;

  // (N+1)-digit BCD adder with decimal carry between digits.
  function automatic logic [DW-1:0] bcd_add(input logic [DW-1:0] x,
                                            input logic [DW-1:0] y);
    logic [DW-1:0] r;
    logic          c;
    logic [4:0]    s;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < N + 1; i++) begin
      s = {1'b0, x[4*i+:4]} + {1'b0, y[4*i+:4]} + {4'b0, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i+:4] = s[3:0];
    end
    return r;
  endfunction

  assign fsm_state = state;
  assign bus.p     = p_q;
  assign bus.lzcnt = lzcnt_q;
  assign bus.done  = done_q;

  // One shared adder: M[k-1]+M1 while building multiples, ACC+M[d] while multiplying.
  always_comb begin
    add_x = acc;
    add_y = '0;
    if (state == PRE) begin
      add_x = '0;
      add_y = m[1];
      for (int k = 2; k <= 9; k++) begin
        if (cnt == 6'(k)) add_x = m[k-1];
      end
    end else begin
      for (int k = 1; k <= 9; k++) begin
        if (br[3:0] == 4'(k)) add_y = m[k];
      end
    end
    sum = bcd_add(add_x, add_y);
  end

  // Leading zero digits of the assembled product, converted to two BCD digits.
  always_comb begin
    full   = {acc[4*N-1:0], br};
    lz_bin = '0;
    seen   = 1'b0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (!seen && full[4*i+:4] == 4'h0) lz_bin = lz_bin + 7'd1;
      else seen = 1'b1;
    end
    lz_bcd = {4'(lz_bin / 7'd10), 4'(lz_bin % 7'd10)};
  end

  // State register; ce freezes the sequencer along with the datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else if (bus.ce) state <= state_nxt;
  end

  // Next-state: ld restarts from any state, otherwise walk PRE -> MUL -> LZC -> IDLE.
  always_comb begin
    state_nxt = state;
    if (bus.ld) begin
      state_nxt = PRE;
    end else begin
      case (state)
        PRE:     if (cnt == 6'd9) state_nxt = MUL;
        MUL:     if (cnt == 6'(N - 1)) state_nxt = LZC;
        LZC:     state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // Datapath: multiples, accumulator/multiplier shift pair, step counter, results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= 9; k++) m[k] <= '0;
      acc     <= '0;
      br      <= '0;
      cnt     <= '0;
      p_q     <= '0;
      lzcnt_q <= '0;
      done_q  <= 1'b1;
    end else if (bus.ce) begin
      if (bus.ld) begin
        m[1]   <= {4'h0, bus.a};
        br     <= bus.b;
        acc    <= '0;
        done_q <= 1'b0;
        cnt    <= 6'd2;
      end else begin
        case (state)
          PRE: begin
            for (int k = 2; k <= 9; k++) begin
              if (cnt == 6'(k)) m[k] <= sum;
            end
            cnt <= (cnt == 6'd9) ? 6'd0 : cnt + 6'd1;
          end
          MUL: begin
            acc <= {4'h0, sum[DW-1:4]};
            br  <= {sum[3:0], br[4*N-1:4]};
            cnt <= cnt + 6'd1;
          end
          LZC: begin
            p_q     <= full;
            lzcnt_q <= lz_bcd;
            done_q  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dfmul_seq.sv
// Bench for dfmul_seq (N=34): vector table with a decimal schoolbook
// reference, plus restart, ld-on-final-edge, clock-enable and reset cases.
module tb_dfmul_seq;

  localparam int N  = 34;
  localparam int PW = 8 * N;
  localparam int W  = PW + 8;

  typedef struct {
    logic [4*N-1:0] a;
    logic [4*N-1:0] b;
    logic [W-1:0]   exp;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] fsm_state;

  logic [W-1:0] exp_q[$];
  int total;
  int bad;

  dfmul_seq_if #(.N(N)) bus ();

  dfmul_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: digit-by-digit schoolbook product with carry normalisation.
  function automatic logic [W-1:0] ref_mul(input logic [4*N-1:0] x,
                                           input logic [4*N-1:0] y);
    int dg[2*N];
    logic [PW-1:0] r;
    int lz;
    bit seen;
    for (int k = 0; k < 2 * N; k++) dg[k] = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        dg[i+j] += int'(x[4*i+:4]) * int'(y[4*j+:4]);
    for (int k = 0; k < 2 * N - 1; k++) begin
      dg[k+1] += dg[k] / 10;
      dg[k]    = dg[k] % 10;
    end
    r = '0;
    for (int k = 0; k < 2 * N; k++) r[4*k+:4] = 4'(dg[k]);
    lz = 0;
    seen = 0;
    for (int k = 2 * N - 1; k >= 0; k--) begin
      if (!seen && dg[k] == 0) lz++;
      else seen = 1;
    end
    return {r, 4'(lz / 10), 4'(lz % 10)};
  endfunction

  function automatic logic [4*N-1:0] rand_bcd(input int nd);
    logic [4*N-1:0] r;
    r = '0;
    for (int k = 0; k < nd; k++) r[4*k+:4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Driver: one-cycle ld pulse; returns just after the capture edge.
  task automatic launch(input logic [4*N-1:0] a, input logic [4*N-1:0] b);
    bus.ce = 1'b1;
    bus.a  = a;
    bus.b  = b;
    bus.ld = 1'b1;
    @(posedge clk);
    #1;
    bus.ld = 1'b0;
  endtask

  // Wait for done with a cycle budget; optionally toggle ce randomly.
  task automatic wait_done(input bit rand_ce, output int cyc, output int ce_hi);
    cyc = 0;
    ce_hi = 0;
    while (!bus.done && cyc < 1000) begin
      if (rand_ce) bus.ce = 1'($urandom_range(0, 1));
      if (bus.ce) ce_hi++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.ce = 1'b1;
    if (!bus.done) begin
      total++;
      bad++;
      $display("FAIL timeout: done still %0b after %0d cycles, want 1", bus.done, cyc);
    end
  endtask

  // Scoreboard: pop the oldest expectation and compare with the DUT outputs.
  task automatic score(input string name);
    logic [W-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got result with empty queue, want a queued expectation", name);
    end else begin
      total--;
      e = exp_q.pop_front();
      check(name, {bus.p, bus.lzcnt}, e);
    end
  endtask

  task automatic run_vec(input string name, input logic [4*N-1:0] a,
                         input logic [4*N-1:0] b, input logic [W-1:0] exp,
                         input bit rand_ce);
    int cyc;
    int ce_hi;
    exp_q.push_back(exp);
    launch(a, b);
    check({name, "_done_fall"}, W'(bus.done), W'(0));
    wait_done(rand_ce, cyc, ce_hi);
    check({name, "_latency"}, W'(ce_hi), W'(N + 9));
    score(name);
  endtask

  initial begin
    vec_t tbl[9];
    logic [4*N-1:0] nines;
    logic [PW-1:0]  nn_p;
    logic [W-1:0]   prev;
    int cyc;
    int ce_hi;

    total = 0;
    bad   = 0;
    nines = {N{4'h9}};
    nn_p  = {{(N-1){4'h9}}, 4'h8, {(N-1){4'h0}}, 4'h1};

    tbl[0] = '{a: 136'h1, b: 136'h1, exp: {272'h1, 8'h67}};
    tbl[1] = '{a: 136'h0, b: nines, exp: {272'h0, 8'h68}};
    tbl[2] = '{a: nines, b: nines, exp: {nn_p, 8'h00}};
    tbl[3] = '{a: 136'h12345678, b: 136'h87654321,
               exp: {272'h1082152022374638, 8'h52}};
    tbl[4] = '{a: 136'h9, b: 136'h9, exp: {272'h81, 8'h66}};
    for (int i = 5; i < 9; i++) begin
      tbl[i].a   = rand_bcd($urandom_range(1, N));
      tbl[i].b   = rand_bcd($urandom_range(1, N));
      tbl[i].exp = ref_mul(tbl[i].a, tbl[i].b);
    end

    // reset
    rst    = 1'b0;
    bus.ce = 1'b1;
    bus.ld = 1'b0;
    bus.a  = '0;
    bus.b  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_p_lz", {bus.p, bus.lzcnt}, W'(0));
    check("reset_done", W'(bus.done), W'(1));
    check("reset_state", W'(fsm_state), W'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // table vectors, issued back-to-back
    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0);

    // random clock enable during a run
    run_vec("ce_rand", 136'h12345678, 136'h87654321, {272'h1082152022374638, 8'h52}, 1'b1);

    // restart 10 cycles into a run; old result must hold meanwhile
    prev = {bus.p, bus.lzcnt};
    launch(136'h12345678, 136'h87654321);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("hold_mid_run", {bus.p, bus.lzcnt}, prev);
    run_vec("restart", 136'h2, 136'h3, {272'h6, 8'h67}, 1'b0);

    // ld on the final edge of a run wins
    launch(136'h7, 136'h8);
    repeat (N + 8) begin
      @(posedge clk);
      #1;
    end
    check("pre_final_done", W'(bus.done), W'(0));
    run_vec("ld_on_lzc", 136'h5, 136'h5, {272'h25, 8'h66}, 1'b0);

    // asynchronous reset mid-run
    launch(nines, nines);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    check("rst_mid_done", W'(bus.done), W'(1));
    check("rst_mid_p_lz", {bus.p, bus.lzcnt}, W'(0));
    check("rst_mid_state", W'(fsm_state), W'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_vec("after_rst", 136'h3, 136'h4, {272'h12, 8'h66}, 1'b0);

    check("queue_empty", W'(exp_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time guard
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/dfmul_seq.md
# dfmul_seq

Sequential BCD significand multiplier for the decimal floating-point unit. It is the multiply-side counterpart of the digit-serial `dfdiv` core. It takes two N-digit packed-BCD significands and produces the 2N-digit exact product plus a BCD leading-zero-digit count, using the same `ld`/`done` handshake as `dfdiv`. The DFP128 multiply wrapper (unpack, exponent add, normalize, round) instantiates it with N=34.

## Interface
- `N`, 34, significand width in BCD digits (4 bits each); legal range 2..49.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ce`  in  1  clock enable; when low, all registers hold, including state and counters.
- `ld`  in  1  start pulse; sampled when `ce`=1.
- `a`  in  N*4  multiplicand, packed BCD.
- `b`  in  N*4  multiplier, packed BCD.
- `p`  out  N*8  product, packed BCD, 2N digits.
- `lzcnt`  out  8  leading zero digits of `p`, two-digit BCD, range 0..2N.
- `done`  out  1  `p` and `lzcnt` valid; idle.

## Operation
- States: IDLE, PRE, MUL, LZC.
- Datapath registers:
  - multiples M1..M9, each N+1 digits;
  - accumulator ACC, N+1 digits;
  - multiplier shift register BR, N digits;
  - step counter.
- `ld`=1 with `ce`=1, in any state:
  - M1 := {0,a}, BR := b, ACC := 0, `done` := 0;
  - step counter := 2; state := PRE.
  - This aborts any operation in progress without error indication.
- PRE, one multiple per cycle:
  - M[k] := M[k-1] + M1, using an (N+1)-digit BCD adder with decimal carry, for k = 2..9.
  - After M9 is written, go to MUL and set the step counter to 0.
- MUL, N cycles, per cycle:
  - d := BR least-significant digit.
  - S := ACC + (d==0 ? 0 : M[d]), N+1 digits. S cannot overflow, because ACC+9·M1 < 10^(N+1).
  - ACC := S >> 1 digit (a zero digit enters at the top).
  - BR := {S digit 0, BR >> 1 digit}.
  - After N steps, go to LZC.
- LZC:
  - `p` := {ACC low N digits, BR}.
  - `lzcnt` := number of consecutive zero digits counted from the top of `p`, converted to BCD. An all-zero product gives 2N (BCD 8'h68 for N=34).
  - `done` := 1; state := IDLE.
- IDLE: hold `p`, `lzcnt` and `done`=1 until the next `ld`.
- Non-BCD input digits (nibble > 9):
  - `p`/`lzcnt` content is unspecified;
  - latency and handshake are unchanged;
  - no hang.

## Timing
- Reset values:
  - `p` = 0, `lzcnt` = 0, `done` = 1;
  - state IDLE, all datapath registers 0.
- Latency: with `ld` accepted at edge E, `done` rises and `p`/`lzcnt` become valid after edge E+N+9 (43 cycles for N=34). The count is:
  - 1 capture edge;
  - 8 PRE edges;
  - N MUL edges;
  - 1 LZC edge, minus the overlapping capture, giving E+N+9.
- `done` falls after edge E and stays low for N+9 cycles.
- `p`/`lzcnt` keep their previous values during computation and update only at the LZC edge.
- `ce`=0 stretches latency cycle-for-cycle; the result is bit-identical to a run with `ce` held high.
- `ld` in the same cycle as the LZC edge: `ld` wins, `done` stays 0, and the new operation starts.
- `rst` asserted mid-operation: all registers return to their reset values immediately; `done`=1 with `p`=0.
- Back-to-back: `ld` in the first cycle after `done` rises is accepted. Throughput is one product per N+9 cycles.

## Test plan
- Reset, then `a`=1, `b`=1 (N=34) -> after 43 cycles:
  - `p` = 1 (BCD), `lzcnt` = 8'h67;
  - `done` is low for exactly 43 cycles.
- `a`=0, `b`=34 nines -> `p` = 0, `lzcnt` = 8'h68.
- `a`=`b`=34 nines -> `p` = 33 nines, then digit 8, then 33 zeros, then digit 1; `lzcnt` = 8'h00.
- `a`=12345678, `b`=87654321 -> `p` = 1082152022374638, `lzcnt` = 8'h52.
- `ce` toggled pseudo-randomly during the 12345678×87654321 run -> same `p`; `done` rises after exactly 43 `ce`-high edges.
- Restart and reset cases:
  - Second `ld` (`a`=2, `b`=3) 10 cycles into a run -> `p` = 6, `done` 43 cycles after the second `ld`.
  - `rst` low mid-run -> `done`=1, `p`=0.
